pc_stack: RTL and testbench
===========================

# pc_stack

Parametrised program counter with a hardware call/return stack, relative branching and selectable address width. Sits in the fetch path of the picoMIPS datapath, driving the program-memory address and replacing the fixed-width increment/branch counter. It advances only in the execute phase of the multi-cycle `cycle` vector. It adds absolute jump, PC-relative branch, subroutine call and return, and sticky stack-error flags.

## Interface
- `ADDR_WIDTH`, default 8: program-memory address width in bits.
- `OFFSET_WIDTH`, default 6: width of the signed relative-branch offset; must be ≤ `ADDR_WIDTH`.
- `STACK_DEPTH`, default 4: number of return-address entries; must be ≥ 1.
- `clk`  in  1  system clock; every register updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising `clk`; overrides all other inputs.
- `cycle`  in  `CYCLE_SIZE`  one-hot phase vector; operations are performed only when `cycle[CYCLE_EXEC]` is 1.
- `op`  in  3  `pc_op_t` operation select.
- `target`  in  `ADDR_WIDTH`  absolute address for JUMP and CALL.
- `offset`  in  `OFFSET_WIDTH`  two's-complement displacement for BRANCH.
- `addr`  out  `ADDR_WIDTH`  current program-memory address (registered).
- `stack_empty`  out  1  stack holds no entries.
- `stack_full`  out  1  stack holds `STACK_DEPTH` entries.
- `overflow`  out  1  sticky; set by a CALL while the stack is full.
- `underflow`  out  1  sticky; set by a RET while the stack is empty.

## Operation
- Operations, applied in the execute phase only:
  - NEXT: `addr` ← `addr`+1.
  - JUMP: `addr` ← `target`.
  - BRANCH: `addr` ← `addr` + sign-extended `offset`.
  - CALL: push `addr`+1, then `addr` ← `target`.
  - RET: `addr` ← popped entry.
  - HOLD: `addr` unchanged.
- Encodings 6–7 are reserved and behave as HOLD.
- Arithmetic is modulo 2^`ADDR_WIDTH`, so carries are discarded. All-ones + 1 gives 0. BRANCH from 0x02 with offset −3 gives 0xFF at width 8.
- The pushed return address wraps the same way.
- CALL with the stack full:
  - jump to `target` is still taken;
  - the push is suppressed and stack contents are unchanged;
  - `overflow` is set.
- RET with the stack empty:
  - behaves as NEXT;
  - the stack pointer is unchanged (no wrap);
  - `underflow` is set.
- `overflow` and `underflow` are cleared only by `reset`.
- When `cycle[CYCLE_EXEC]` is 0, `op`, `target` and `offset` are ignored. No state changes, including error flags.
- `stack_empty` and `stack_full` are decoded from the registered stack pointer (count 0..`STACK_DEPTH`).

## Timing
- Reset values:
  - `addr` = 0;
  - stack pointer = 0, so `stack_empty` = 1 and `stack_full` = 0 (`stack_full` = 0 even when `STACK_DEPTH` = 1);
  - `overflow` = 0, `underflow` = 0.
- Stack entry contents are don't-care after reset.
- Latency is one cycle. An operation sampled with exec high at edge N is visible on `addr` and the flags after edge N.
- `reset` high on an exec edge wins. The operation is discarded and all state is cleared, including mid-call-sequence.
- Push and pop never coincide, because an op is exactly one of CALL or RET. Back-to-back exec cycles are legal: a RET immediately after a CALL returns the address just pushed.
- There is no combinational path from any input to `addr`.

## Structure
- The `pc_op_t` enum (NEXT=0, JUMP=1, BRANCH=2, CALL=3, RET=4, HOLD=5) lives in the shared package next to the `CYCLE_SIZE`/`CYCLE_EXEC` constants. The decoder and testbench import it from there.
- One sub-module: `lifo_stack`, parametrised on WIDTH and DEPTH.
  - Inputs: `push`, `pop`, `din`.
  - Outputs: `dout` (top of stack), `empty`, `full`.
  - It ignores a push when full and a pop when empty. `pc_stack` derives the error flags from the request plus `full`/`empty`.
- The next-address multiplexer is inline `always_comb`.

## Test plan
All scenarios use defaults (8/6/4).
- Reset and increment:
  - assert `reset` for 1 cycle, then 3 exec cycles of NEXT → `addr` 0,1,2,3, `stack_empty`=1;
  - NEXT with exec low → `addr` holds.
- Wrap and relative branch:
  - JUMP 0xFE, NEXT, NEXT → 0xFE, 0xFF, 0x00;
  - from 0x02, BRANCH offset 6'b111101 → 0xFF;
  - from 0x10, BRANCH +31 → 0x2F.
- Nested calls:
  - at 0x05, CALL 0x40, then at 0x40 CALL 0x80 → `addr` 0x80, 2 entries held;
  - RET → 0x41; RET → 0x06, `stack_empty`=1.
- Overflow:
  - 4 CALLs → `stack_full`=1;
  - 5th CALL 0x90 → `addr`=0x90, `overflow`=1;
  - 4 RETs return the first four return addresses in LIFO order;
  - `overflow` stays 1 until `reset`.
- Underflow: RET on an empty stack at 0x20 → `addr`=0x21, `underflow`=1, `stack_empty` stays 1.
- Reset mid-operation: `reset` with exec and CALL 0x33 on the same edge → `addr`=0, `stack_empty`=1, both flags 0.

Source files
------------

// File: rtl/pc_stack_pkg.sv
// Shared types and constants for the picoMIPS program counter and its decoder.
package pc_stack_pkg;

  localparam int CYCLE_SIZE = 3;
  localparam int CYCLE_EXEC = 2;

  typedef enum logic [2:0] {
    PC_NEXT   = 3'd0,
    PC_JUMP   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_CALL   = 3'd3,
    PC_RET    = 3'd4,
    PC_HOLD   = 3'd5
  } pc_op_t;

endpackage

// File: rtl/lifo_stack.sv
// Return-address LIFO; silently ignores push when full and pop when empty.
module lifo_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH + 1);

  logic [PW-1:0]    ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (ptr == '0);
  assign full  = (ptr == PW'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (push && !full)
      ptr <= ptr + 1'b1;
    else if (pop && !empty)
      ptr <= ptr - 1'b1;
  end

  // Entries carry no reset; the pointer alone defines what is valid.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    always_ff @(posedge clk) begin
      if (!reset && push && !full && ptr == PW'(i))
        mem[i] <= din;
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ptr == PW'(i + 1)) dout = mem[i];
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with call/return stack, relative branch and sticky stack-error flags.
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int OFFSET_WIDTH = 6,
  parameter int STACK_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CYCLE_SIZE-1:0]   cycle,
  input  logic [2:0]              op,
  input  logic [ADDR_WIDTH-1:0]   target,
  input  logic [OFFSET_WIDTH-1:0] offset,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic                    stack_empty,
  output logic                    stack_full,
  output logic                    overflow,
  output logic                    underflow
);

  logic                  exec;
  logic [ADDR_WIDTH-1:0] addr_inc, addr_nxt, off_ext, top;
  logic                  push, pop, set_ovf, set_unf;

  assign exec     = cycle[CYCLE_EXEC];
  assign addr_inc = addr + 1'b1;
  assign off_ext  = ADDR_WIDTH'($signed(offset));

  lifo_stack #(.WIDTH(ADDR_WIDTH), .DEPTH(STACK_DEPTH)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (addr_inc),
    .dout  (top),
    .empty (stack_empty),
    .full  (stack_full)
  );

  always_comb begin
    addr_nxt = addr;
    push     = 1'b0;
    pop      = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    if (exec) begin
      case (op)
        PC_NEXT:   addr_nxt = addr_inc;
        PC_JUMP:   addr_nxt = target;
        PC_BRANCH: addr_nxt = addr + off_ext;
        PC_CALL: begin
          addr_nxt = target;
          push     = !stack_full;
          set_ovf  = stack_full;
        end
        PC_RET: begin
          // An empty-stack return degrades to a plain increment.
          addr_nxt = stack_empty ? addr_inc : top;
          pop      = !stack_empty;
          set_unf  = stack_empty;
        end
        default: addr_nxt = addr;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      addr      <= addr_nxt;
      overflow  <= overflow | set_ovf;
      underflow <= underflow | set_unf;
    end
  end

endmodule

// File: tb/tb_pc_stack.sv
// Directed-vector bench for pc_stack at default parameters.
module tb_pc_stack;
  import pc_stack_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [CYCLE_SIZE-1:0] cycle;
  logic [2:0]            op;
  logic [7:0]            target;
  logic [5:0]            offset;
  logic [7:0]            addr;
  logic                  stack_empty, stack_full, overflow, underflow;

  int n_vec = 0;
  int n_err = 0;

  pc_stack dut (
    .clk         (clk),
    .reset       (reset),
    .cycle       (cycle),
    .op          (op),
    .target      (target),
    .offset      (offset),
    .addr        (addr),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Apply one op for one clock edge, then settle 1 time unit past the edge.
  task automatic step(input logic [2:0] o, input logic [7:0] t, input logic [5:0] ofs,
                      input logic ex);
    op     = o;
    target = t;
    offset = ofs;
    cycle  = ex ? CYCLE_SIZE'(1 << CYCLE_EXEC) : CYCLE_SIZE'(1);
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input string tag, input logic e, input logic f,
                       input logic ov, input logic un);
    chk({tag, ".empty"}, 32'(stack_empty), 32'(e));
    chk({tag, ".full"},  32'(stack_full),  32'(f));
    chk({tag, ".ovf"},   32'(overflow),    32'(ov));
    chk({tag, ".unf"},   32'(underflow),   32'(un));
  endtask

  initial begin
    reset = 1'b1;
    step(PC_NEXT, 8'h00, 6'd0, 1'b1);
    reset = 1'b0;
    chk("rst.addr", 32'(addr), 32'h00);
    flags("rst", 1, 0, 0, 0);

    // Increment, then exec-low hold
    step(PC_NEXT, 8'h00, 6'd0, 1'b1); chk("inc1", 32'(addr), 32'h01);
    step(PC_NEXT, 8'h00, 6'd0, 1'b1); chk("inc2", 32'(addr), 32'h02);
    step(PC_NEXT, 8'h00, 6'd0, 1'b1); chk("inc3", 32'(addr), 32'h03);
    chk("inc.empty", 32'(stack_empty), 32'd1);
    step(PC_NEXT, 8'h00, 6'd0, 1'b0); chk("noexec", 32'(addr), 32'h03);
    step(PC_HOLD, 8'h00, 6'd0, 1'b1); chk("hold", 32'(addr), 32'h03);
    step(3'd6, 8'h77, 6'd0, 1'b1);    chk("rsv6", 32'(addr), 32'h03);
    step(3'd7, 8'h77, 6'd0, 1'b1);    chk("rsv7", 32'(addr), 32'h03);

    // Wrap and relative branch
    step(PC_JUMP, 8'hFE, 6'd0, 1'b1); chk("jmp.fe", 32'(addr), 32'hFE);
    step(PC_NEXT, 8'h00, 6'd0, 1'b1); chk("wrap.ff", 32'(addr), 32'hFF);
    step(PC_NEXT, 8'h00, 6'd0, 1'b1); chk("wrap.00", 32'(addr), 32'h00);
    step(PC_JUMP, 8'h02, 6'd0, 1'b1);
    step(PC_BRANCH, 8'h00, 6'b111101, 1'b1); chk("br.neg", 32'(addr), 32'hFF);
    step(PC_JUMP, 8'h10, 6'd0, 1'b1);
    step(PC_BRANCH, 8'h00, 6'b011111, 1'b1); chk("br.pos", 32'(addr), 32'h2F);

    // Nested calls
    step(PC_JUMP, 8'h05, 6'd0, 1'b1);
    step(PC_CALL, 8'h40, 6'd0, 1'b1); chk("call1", 32'(addr), 32'h40);
    step(PC_CALL, 8'h80, 6'd0, 1'b1); chk("call2", 32'(addr), 32'h80);
    flags("nest", 0, 0, 0, 0);
    step(PC_RET, 8'h00, 6'd0, 1'b1);  chk("ret1", 32'(addr), 32'h41);
    step(PC_RET, 8'h00, 6'd0, 1'b1);  chk("ret2", 32'(addr), 32'h06);
    chk("ret2.empty", 32'(stack_empty), 32'd1);

    // Overflow: four pushes fill, fifth jumps without pushing
    step(PC_CALL, 8'h10, 6'd0, 1'b1);
    step(PC_CALL, 8'h20, 6'd0, 1'b1);
    step(PC_CALL, 8'h30, 6'd0, 1'b1);
    step(PC_CALL, 8'h40, 6'd0, 1'b1);
    flags("fill", 0, 1, 0, 0);
    step(PC_CALL, 8'h90, 6'd0, 1'b1); chk("ovf.addr", 32'(addr), 32'h90);
    flags("ovf", 0, 1, 1, 0);
    step(PC_CALL, 8'hA0, 6'd0, 1'b0); chk("ovf.noexec", 32'(addr), 32'h90);
    step(PC_RET, 8'h00, 6'd0, 1'b1);  chk("pop4", 32'(addr), 32'h31);
    step(PC_RET, 8'h00, 6'd0, 1'b1);  chk("pop3", 32'(addr), 32'h21);
    step(PC_RET, 8'h00, 6'd0, 1'b1);  chk("pop2", 32'(addr), 32'h11);
    step(PC_RET, 8'h00, 6'd0, 1'b1);  chk("pop1", 32'(addr), 32'h07);
    flags("drain", 1, 0, 1, 0);

    // Underflow
    step(PC_JUMP, 8'h20, 6'd0, 1'b1);
    step(PC_RET, 8'h00, 6'd0, 1'b1);  chk("unf.addr", 32'(addr), 32'h21);
    flags("unf", 1, 0, 1, 1);

    // Back-to-back call/return
    step(PC_CALL, 8'h50, 6'd0, 1'b1); chk("b2b.call", 32'(addr), 32'h50);
    step(PC_RET, 8'h00, 6'd0, 1'b1);  chk("b2b.ret", 32'(addr), 32'h22);
    step(PC_CALL, 8'h60, 6'd0, 1'b1); chk("pre.rst", 32'(addr), 32'h60);

    // Reset wins over an exec CALL on the same edge
    reset = 1'b1;
    step(PC_CALL, 8'h33, 6'd0, 1'b1);
    reset = 1'b0;
    chk("rst2.addr", 32'(addr), 32'h00);
    flags("rst2", 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
